// File: rtl/instr_fetch_buffer_if.sv
// Bundle of the memory-side fetch handshake, redirect and decode-side instruction handshake.
// master is the fetch buffer; slave is the environment (memory + core).
interface instr_fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_code, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_code, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer: issues in-order word fetches, tags each response with its
// request address, queues it for decode, and flushes stale responses after a redirect.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_buffer_if.master   bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    typedef enum logic {FETCH, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   aq_wptr_q, aq_wptr_d;
    logic [PTR_W-1:0]   aq_rptr_q, aq_rptr_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic [31:0]        code_q, code_d;
    logic [31:0]        ipc_q, ipc_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] tag_mem  [DEPTH];
    logic [31:0] aq_mem   [DEPTH];

    logic             gnt_fire;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic [31:0]      rsp_addr;
    logic [CNT_W-1:0] remain;

    assign gnt_fire = bus.imem_req && bus.imem_gnt;
    // Responses with nothing outstanding are stray (e.g. from before a reset) and are dropped.
    assign rsp_fire = bus.imem_rvalid && (out_q != '0);
    assign push     = rsp_fire && (state_q == FETCH) && !bus.redirect;
    assign pop      = valid_q && bus.instr_ready;
    assign rsp_addr = aq_mem[aq_rptr_q];
    assign remain   = count_q - CNT_W'(pop);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        out_d     = out_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        aq_wptr_d = aq_wptr_q;
        aq_rptr_d = aq_rptr_q;
        code_d    = code_q;
        ipc_d     = ipc_q;

        case ({gnt_fire, rsp_fire})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase

        if (gnt_fire) begin
            pc_d      = pc_q + 32'd4;
            aq_wptr_d = aq_wptr_q + PTR_W'(1);
        end
        if (rsp_fire) begin
            aq_rptr_d = aq_rptr_q + PTR_W'(1);
        end

        if (bus.redirect) begin
            pc_d    = bus.redirect_pc & ~32'h3;
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            state_d = (out_d != '0) ? FLUSH : FETCH;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if ((state_q == FLUSH) && (out_d == '0)) state_d = FETCH;
        end

        // Head registers: bypass the incoming word when it lands in an otherwise empty FIFO.
        if (count_d != '0) begin
            if (remain == '0) begin
                code_d = bus.imem_rdata;
                ipc_d  = rsp_addr;
            end else begin
                code_d = data_mem[rptr_d];
                ipc_d  = tag_mem[rptr_d];
            end
        end

        valid_d = (count_d != '0);
        req_d   = (state_d == FETCH) && (({1'b0, count_d} + {1'b0, out_d}) < DEPTH_L);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= bus.imem_rdata;
            tag_mem[wptr_q]  <= rsp_addr;
        end
        if (gnt_fire) begin
            aq_mem[aq_wptr_q] <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC & ~32'h3;
            out_q     <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            aq_wptr_q <= '0;
            aq_rptr_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_q     <= out_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            aq_wptr_q <= aq_wptr_d;
            aq_rptr_q <= aq_rptr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ipc_q     <= ipc_d;
        end
    end

    // A redirect must silence the request in the same cycle it arrives.
    assign bus.imem_req    = req_q && !bus.redirect;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_code  = code_q;
    assign bus.instr_pc    = ipc_q;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: in-order memory model with 1-cycle response latency
// and a log of granted addresses and consumed instructions.
module tb_instr_fetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_buffer_if bus ();

    instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit auto_rsp = 1'b0;

    logic [31:0] pend[$];
    logic [31:0] gnt_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_code[$];
    int          cons_cyc[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] cpc(input int i);
        if (i < cons_pc.size()) return cons_pc[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] ccode(input int i);
        if (i < cons_code.size()) return cons_code[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] glog(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        g, rv, cons;
        logic [31:0] ga, cp, cc;
        @(negedge clk);
        g    = bus.imem_req && bus.imem_gnt;
        ga   = bus.imem_addr;
        rv   = bus.imem_rvalid;
        cons = bus.instr_valid && bus.instr_ready;
        cp   = bus.instr_pc;
        cc   = bus.instr_code;
        @(posedge clk);
        cyc++;
        #1;
        if (cons) begin
            cons_pc.push_back(cp);
            cons_code.push_back(cc);
            cons_cyc.push_back(cyc);
            $display("t=%0t consume pc=%h code=%h", $time, cp, cc);
        end
        if (rv && pend.size() > 0) void'(pend.pop_front());
        if (g) begin
            gnt_log.push_back(ga);
            pend.push_back(ga);
            $display("t=%0t grant addr=%h", $time, ga);
        end
        if (auto_rsp && pend.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memf(pend[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        tick();
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_code",  bus.instr_code, 32'h0);
        chk("rst_pc",    bus.instr_pc, 32'h0);
        rst = 1'b1;
        tick();
        chk("rel_req",  32'(bus.imem_req), 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h0);

        // Streaming: grant every cycle, one instruction per cycle
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; auto_rsp = 1'b1;
        repeat (8) tick();
        bus.imem_gnt = 1'b0;
        repeat (4) tick();
        chk("stream_count", 32'(cons_pc.size()), 32'd8);
        for (int i = 0; i < 6; i++) begin
            chk("stream_pc",   cpc(i),   32'(4 * i));
            chk("stream_code", ccode(i), memf(32'(4 * i)));
        end
        chk("stream_rate", (cons_cyc.size() >= 6) ? 32'(cons_cyc[5] - cons_cyc[0]) : 32'hFFFF, 32'd5);

        // Back-pressure: FIFO fills with exactly DEPTH entries
        do_redirect(32'h0);
        gnt_log.delete(); cons_pc.delete(); cons_code.delete(); cons_cyc.delete();
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0;
        repeat (10) tick();
        chk("full_grants", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("full_addr", glog(i), 32'(4 * i));
        chk("full_req",   32'(bus.imem_req), 32'd0);
        chk("full_valid", 32'(bus.instr_valid), 32'd1);
        chk("full_pc",    bus.instr_pc, 32'h0);
        chk("full_code",  bus.instr_code, memf(32'h0));
        bus.instr_ready = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) chk("drain_pc", cpc(i), 32'(4 * i));
        chk("resume_addr", glog(4), 32'h10);
        bus.imem_gnt = 1'b0;
        repeat (6) tick();

        // Grant stall: request and address hold
        do_redirect(32'h200);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req",  32'(bus.imem_req), 32'd1);
            chk("stall_addr", bus.imem_addr, 32'h200);
        end

        // Redirect with three outstanding
        auto_rsp = 1'b0; bus.imem_gnt = 1'b1;
        gnt_log.delete();
        repeat (3) tick();
        chk("flush_out3", 32'(gnt_log.size()), 32'd3);
        do_redirect(32'h0000_0103);
        chk("flush_req0",  32'(bus.imem_req), 32'd0);
        chk("flush_addr",  bus.imem_addr, 32'h100);
        auto_rsp = 1'b1;
        cons_pc.delete(); cons_code.delete(); cons_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_req",   32'(bus.imem_req), 32'd0);
            chk("flush_valid", 32'(bus.instr_valid), 32'd0);
        end
        tick();
        chk("flush_exit_req",  32'(bus.imem_req), 32'd1);
        chk("flush_exit_addr", bus.imem_addr, 32'h100);
        repeat (5) tick();
        chk("flush_first_pc",   cpc(0),   32'h100);
        chk("flush_first_code", ccode(0), memf(32'h100));
        bus.imem_gnt = 1'b0;
        repeat (4) tick();

        // Fetch PC wrap-around
        do_redirect(32'hFFFF_FFF8);
        gnt_log.delete(); cons_pc.delete(); cons_code.delete(); cons_cyc.delete();
        bus.imem_gnt = 1'b1;
        repeat (3) tick();
        bus.imem_gnt = 1'b0;
        repeat (4) tick();
        chk("wrap_g0", glog(0), 32'hFFFF_FFF8);
        chk("wrap_g1", glog(1), 32'hFFFF_FFFC);
        chk("wrap_g2", glog(2), 32'h0000_0000);
        chk("wrap_c0", cpc(0), 32'hFFFF_FFF8);
        chk("wrap_c1", cpc(1), 32'hFFFF_FFFC);
        chk("wrap_c2", cpc(2), 32'h0000_0000);
        chk("wrap_code1", ccode(1), memf(32'hFFFF_FFFC));

        // Reset with two requests in flight; late responses must be ignored
        do_redirect(32'h300);
        auto_rsp = 1'b0; bus.imem_gnt = 1'b1;
        gnt_log.delete();
        repeat (2) tick();
        bus.imem_gnt = 1'b0;
        chk("mid_out2", 32'(gnt_log.size()), 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_req",   32'(bus.imem_req), 32'd0);
        chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_rst_addr",  bus.imem_addr, 32'h0);
        chk("mid_rst_code",  bus.instr_code, 32'h0);
        chk("mid_rst_pc",    bus.instr_pc, 32'h0);
        repeat (2) tick();
        rst = 1'b1; auto_rsp = 1'b1;
        cons_pc.delete(); cons_code.delete(); cons_cyc.delete();
        tick();
        chk("mid_rel_req",  32'(bus.imem_req), 32'd1);
        chk("mid_rel_addr", bus.imem_addr, 32'h0);
        repeat (2) tick();
        chk("late_valid", 32'(bus.instr_valid), 32'd0);
        chk("late_req",   32'(bus.imem_req), 32'd1);
        bus.imem_gnt = 1'b1;
        repeat (4) tick();
        bus.imem_gnt = 1'b0;
        repeat (3) tick();
        chk("late_first_pc",   cpc(0),   32'h0);
        chk("late_first_code", ccode(0), memf(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
